// File: rtl/crc_frame_seq.sv
// Frame CRC sequencer: latches per-frame config on start and runs a bytewise CRC over a valid/ready beat stream.
// The result is valid 2 cycles after the last beat (or after a zero-length start) and is held until res_ready.
module crc_frame_seq #(
    parameter int DATA_BYTES = 8,
    parameter int CRC_WIDTH  = 32,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [CRC_WIDTH-1:0]    cfg_poly,
    input  logic [CRC_WIDTH-1:0]    cfg_init,
    input  logic                    cfg_refin,
    input  logic                    cfg_refout,
    input  logic [CRC_WIDTH-1:0]    cfg_xorout,
    input  logic                    abort,
    input  logic                    s_valid,
    input  logic [DATA_BYTES*8-1:0] s_data,
    output logic                    s_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CRC_WIDTH-1:0]    crc_result,
    output logic                    busy,
    output logic [LEN_W-1:0]        beat_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

    localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(DATA_BYTES);

    state_t               r_state;
    logic [CRC_WIDTH-1:0] r_poly;
    logic [CRC_WIDTH-1:0] r_xorout;
    logic [CRC_WIDTH-1:0] r_crc;
    logic [CRC_WIDTH-1:0] r_result;
    logic                 r_refin;
    logic                 r_refout;
    logic [LEN_W-1:0]     r_rem;
    logic [LEN_W-1:0]     r_beat_cnt;

    logic [LEN_W-1:0]     w_nbytes;
    logic [CRC_WIDTH-1:0] w_crc_next;
    logic [CRC_WIDTH-1:0] w_result;
    logic [7:0]           w_byte;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[7-k];
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] rev_crc(input logic [CRC_WIDTH-1:0] v);
        logic [CRC_WIDTH-1:0] r;
        for (int k = 0; k < CRC_WIDTH; k++) r[k] = v[CRC_WIDTH-1-k];
        return r;
    endfunction

    // Bytes at or beyond the remaining count on the final beat are masked out.
    always_comb begin
        w_nbytes   = (r_rem < BEAT_BYTES) ? r_rem : BEAT_BYTES;
        w_crc_next = r_crc;
        w_byte     = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (LEN_W'(i) < w_nbytes) begin
                w_byte     = r_refin ? rev8(s_data[i*8 +: 8]) : s_data[i*8 +: 8];
                w_crc_next = w_crc_next ^ (CRC_WIDTH'(w_byte) << (CRC_WIDTH-8));
                for (int j = 0; j < 8; j++) begin
                    w_crc_next = w_crc_next[CRC_WIDTH-1] ? ((w_crc_next << 1) ^ r_poly)
                                                         : (w_crc_next << 1);
                end
            end
        end
        w_result = (r_refout ? rev_crc(r_crc) : r_crc) ^ r_xorout;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_poly     <= '0;
            r_xorout   <= '0;
            r_crc      <= '0;
            r_result   <= '0;
            r_refin    <= 1'b0;
            r_refout   <= 1'b0;
            r_rem      <= '0;
            r_beat_cnt <= '0;
        end else if (abort) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_poly     <= cfg_poly;
                        r_xorout   <= cfg_xorout;
                        r_refin    <= cfg_refin;
                        r_refout   <= cfg_refout;
                        r_crc      <= cfg_init;
                        r_rem      <= cfg_len;
                        r_beat_cnt <= '0;
                        r_state    <= (cfg_len != '0) ? RUN : FINISH;
                    end
                end
                RUN: begin
                    if (s_valid) begin
                        r_crc <= w_crc_next;
                        r_rem <= r_rem - w_nbytes;
                        if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_rem == w_nbytes) r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_result <= w_result;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (res_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready    = (r_state == RUN);
    assign res_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign crc_result = r_result;
    assign beat_cnt   = r_beat_cnt;

endmodule

// File: tb/tb_crc_frame_seq.sv
// Bench for crc_frame_seq: directed CRC-32 / MPEG-2 vectors, backpressure, abort, async reset,
// then random frames scored against a bit-serial CRC model.
module tb_crc_frame_seq;
    localparam int DB = 8;
    localparam int CW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [LW-1:0] cfg_len;
    logic [CW-1:0] cfg_poly, cfg_init, cfg_xorout;
    logic          cfg_refin, cfg_refout;
    logic          abort;
    logic          s_valid;
    logic [DB*8-1:0] s_data;
    logic          s_ready;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] crc_result;
    logic          busy;
    logic [LW-1:0] beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  msg[$];
    bit          fill_rand = 1'b0;
    logic [31:0] last_result = '0;

    crc_frame_seq #(.DATA_BYTES(DB), .CRC_WIDTH(CW), .LEN_W(LW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .cfg_len(cfg_len),
        .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_refin(cfg_refin),
        .cfg_refout(cfg_refout), .cfg_xorout(cfg_xorout), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .res_valid(res_valid), .res_ready(res_ready), .crc_result(crc_result),
        .busy(busy), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: each message bit shifted through the register one at a time.
    function automatic logic [31:0] ref_crc(input logic [31:0] poly, input logic [31:0] init,
                                            input bit refin, input bit refout,
                                            input logic [31:0] xorout, input int len);
        logic [31:0] c = init;
        logic [31:0] r;
        logic        fb;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ msg[i][refin ? k : 7-k];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ poly;
            end
        end
        if (refout) begin
            for (int k = 0; k < 32; k++) r[k] = c[31-k];
            c = r;
        end
        return c ^ xorout;
    endfunction

    task automatic load_check_msg();
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    task automatic drive_beat(input int idx, input int len);
        for (int k = 0; k < DB; k++)
            s_data[k*8 +: 8] = (idx + k < len) ? msg[idx+k] : (fill_rand ? 8'($urandom) : 8'hAA);
    endtask

    task automatic set_cfg(input int len, input logic [31:0] poly, input logic [31:0] init,
                           input bit refin, input bit refout, input logic [31:0] xorout);
        cfg_len = LW'(len); cfg_poly = poly; cfg_init = init;
        cfg_refin = refin; cfg_refout = refout; cfg_xorout = xorout;
    endtask

    task automatic scramble_cfg();
        set_cfg(int'($urandom_range(1, 50)), $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom);
    endtask

    task automatic run_frame(input int len, input logic [31:0] poly, input logic [31:0] init,
                             input bit refin, input bit refout, input logic [31:0] xorout,
                             input bit gaps, input logic [31:0] exp_crc, input int hold);
        int idx = 0, rem = len, beats = 0, cyc = 0, n;
        bit hs;
        set_cfg(len, poly, init, refin, refout, xorout);
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cfg();
        while (rem > 0 && cyc < 1000) begin
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_beat(idx, len);
            check("s_ready_run", s_ready, 1'b1);
            hs = s_valid;
            tick();
            cyc++;
            if (hs) begin
                n = (rem < DB) ? rem : DB;
                rem -= n; idx += n; beats++;
            end
        end
        s_valid = 1'b0;
        if (rem != 0) check("handshake_budget", 64'(rem), 64'd0);
        check("finish_s_ready", s_ready, 1'b0);
        check("finish_res_valid", res_valid, 1'b0);
        check("finish_busy", busy, 1'b1);
        tick();
        check("res_valid", res_valid, 1'b1);
        check("crc_result", crc_result, exp_crc);
        check("beat_cnt", beat_cnt, LW'(beats));
        for (int h = 0; h < hold; h++) begin
            start = (h == 3);
            tick();
            check("hold_res_valid", res_valid, 1'b1);
            check("hold_crc", crc_result, exp_crc);
            check("hold_busy", busy, 1'b1);
        end
        start = (hold > 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_res_valid", res_valid, 1'b0);
        last_result = exp_crc;
        if (hold > 0) begin
            tick();
            check("start_ignored", busy, 1'b0);
            check("result_kept", crc_result, exp_crc);
        end
    endtask

    initial begin
        int len;
        logic [31:0] p, i0, xo;
        bit ri, ro, gp;

        n_rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        res_ready = 1'b0;
        set_cfg(0, '0, '0, 1'b0, 1'b0, '0);
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_crc", crc_result, 32'h0);
        check("rst_beat_cnt", beat_cnt, 16'h0);
        tick(); tick();
        @(negedge clk) n_rst = 1'b1;
        tick();

        load_check_msg();
        run_frame(9, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hCBF43926, 0);
        run_frame(9, 32'h04C11DB7, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0376E6E7, 0);
        run_frame(9, 32'h04C11DB7, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0376E6E7, 0);
        run_frame(0, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000000, 0);
        run_frame(9, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hCBF43926, 10);

        // Abort after the first beat; a simultaneous start must lose to abort.
        set_cfg(9, 32'h04C11DB7, 32'h0, 1'b0, 1'b0, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        drive_beat(0, 9);
        tick();
        s_valid = 1'b0;
        check("abort_pre_beat_cnt", beat_cnt, 16'd1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_s_ready", s_ready, 1'b0);
        check("abort_res_valid", res_valid, 1'b0);
        check("abort_crc_kept", crc_result, last_result);
        run_frame(9, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hCBF43926, 0);

        // Asynchronous reset between edges while in RUN.
        set_cfg(9, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        drive_beat(0, 9);
        tick();
        s_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_s_ready", s_ready, 1'b0);
        check("arst_res_valid", res_valid, 1'b0);
        check("arst_crc", crc_result, 32'h0);
        check("arst_beat_cnt", beat_cnt, 16'h0);
        @(negedge clk) n_rst = 1'b1;
        tick();
        run_frame(9, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hCBF43926, 0);

        fill_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            len = int'($urandom_range(0, 40));
            msg.delete();
            for (int b = 0; b < len; b++) msg.push_back(8'($urandom));
            p = $urandom; i0 = $urandom; xo = $urandom;
            ri = 1'($urandom); ro = 1'($urandom); gp = 1'($urandom);
            run_frame(len, p, i0, ri, ro, xo, gp, ref_crc(p, i0, ri, ro, xo, len), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
